fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the 32-bit x 1024-word instruction memory.
- Owns the program counter and drives the word index into instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles stall, branch/jump redirect with flush, misaligned-target trap, and halt on ECALL.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
PC_W, 32, PC width in bits
IDX_W, 10, instruction-memory word-index width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_out  output  IDX_W  word index to instruction memory = pc[IDX_W+1:2] (combinational from PC register)
insn_in  input  32  instruction returned combinationally by instruction memory for pc_out
stall  input  1  hazard stall from decode; hold PC and IF/ID
redirect  input  1  taken branch / jump from execute
redirect_pc  input  PC_W  byte target of redirect
id_insn  output  32  IF/ID instruction
id_pc  output  PC_W  IF/ID byte PC of id_insn
id_valid  output  1  IF/ID contents valid
halted  output  1  high while in HALT
misalign_err  output  1  sticky: redirect target not word-aligned

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, id_insn=32'h0000_0013 (NOP), id_pc=0, id_valid=0, halted=0, misalign_err=0. Reset asserted mid-operation aborts everything immediately; no partial state survives.
- States: BOOT, RUN, HALT. halted = (state==HALT).
- BOOT: lasts exactly one cycle after rst_n rises; PC and IF/ID held, id_valid=0; next state RUN. The first valid instruction appears at id_insn on the 2nd rising edge after reset release.
- RUN, per rising edge, priority is redirect > stall > advance:
  - redirect=1, redirect_pc[1:0]==0: pc<=redirect_pc; id_insn<=NOP; id_valid<=0 (flush the wrong-path instruction); stays RUN. Redirect overrides a simultaneous stall.
  - redirect=1, redirect_pc[1:0]!=0: pc unchanged; flush IF/ID as above; misalign_err<=1; next state HALT.
  - stall=1 (no redirect): pc, id_insn, id_pc, id_valid all held.
  - advance: id_insn<=insn_in; id_pc<=pc; id_valid<=1; pc<=pc+4.
  - If advancing and insn_in==32'h0000_0073 (ECALL): the ECALL is captured valid, pc is not incremented, next state HALT.
- HALT: pc frozen and redirect ignored. If stall=1, IF/ID held so downstream can still consume a pending ECALL. Else id_valid<=0 and id_insn<=NOP. Exit only via reset.
- Arithmetic: pc+4 is modulo 2^PC_W. pc_out wraps naturally: byte 4092 gives index 1023, next byte 4096 gives index 0. No error on wrap.
- pc_out is combinational from the PC register only; there is no combinational path from stall or redirect to pc_out.
- misalign_err is sticky until reset.
- Latency: one cycle from PC to IF/ID. Redirect-to-first-target-instruction valid is 2 edges: the redirect edge, then the fetch edge.

Test Plan:
- Reset release, memory holds 0x00208093 at index 0 and 0x40310133 at index 1, no stall/redirect -> edge 1 id_valid=0 (BOOT); edge 2 id_insn=0x00208093, id_pc=0; edge 3 id_insn=0x40310133, id_pc=4; pc_out=2.
- Stall held 3 cycles while id_pc=8 -> id_insn/id_pc/id_valid and pc_out=3 unchanged throughout; the cycle after stall drops, id_pc=12.
- redirect=1, redirect_pc=0x40 with stall=1 on the same edge -> id_valid=0, id_insn=0x00000013, pc_out=16; next edge id_pc=0x40, id_valid=1.
- redirect_pc=0x42 -> misalign_err=1, halted=1 next edge, pc_out unchanged, id_valid=0; later redirect to 0x0 ignored.
- ECALL (0x00000073) at index 5 -> captured with id_pc=20, id_valid=1, halted=1; next non-stall edge id_valid=0; pc_out stays 5 indefinitely.
- RESET_PC=4092 -> first instruction taken from index 1023, second from index 0 with id_pc=4096; asserting rst_n=0 mid-run immediately clears id_valid and returns pc_out to 1023.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory lookup, decode-side control and the IF/ID register outputs.
interface fetch_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 10
);
    logic [IDX_W-1:0] pc_out;
    logic [31:0]      insn_in;
    logic             stall;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;
    logic [31:0]      id_insn;
    logic [PC_W-1:0]  id_pc;
    logic             id_valid;
    logic             halted;
    logic             misalign_err;

    modport master (
        output pc_out,
        input  insn_in,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output id_insn,
        output id_pc,
        output id_valid,
        output halted,
        output misalign_err
    );

    modport slave (
        input  pc_out,
        output insn_in,
        output stall,
        output redirect,
        output redirect_pc,
        input  id_insn,
        input  id_pc,
        input  id_valid,
        input  halted,
        input  misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, indexes instruction memory and fills the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32,
    parameter int          IDX_W    = 10
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [31:0]     id_insn_q, id_insn_nxt;
    logic [PC_W-1:0] id_pc_q, id_pc_nxt;
    logic            id_valid_q, id_valid_nxt;
    logic            err_q, err_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc         <= PC_W'(RESET_PC);
            id_insn_q  <= NOP;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            id_insn_q  <= id_insn_nxt;
            id_pc_q    <= id_pc_nxt;
            id_valid_q <= id_valid_nxt;
            err_q      <= err_nxt;
        end
    end

    // NOTE: every output of this block is defaulted to its held value first, so no latch can be inferred.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        id_insn_nxt  = id_insn_q;
        id_pc_nxt    = id_pc_q;
        id_valid_nxt = id_valid_q;
        err_nxt      = err_q;

        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (bus.redirect) begin
                    // A redirect always squashes the wrong-path instruction, even when it traps.
                    id_insn_nxt  = NOP;
                    id_valid_nxt = 1'b0;
                    if (bus.redirect_pc[1:0] == 2'b00) begin
                        pc_nxt = bus.redirect_pc;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end else if (!bus.stall) begin
                    id_insn_nxt  = bus.insn_in;
                    id_pc_nxt    = pc;
                    id_valid_nxt = 1'b1;
                    if (bus.insn_in == ECALL) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt = pc + PC_W'(4);
                    end
                end
            end
            HALT: begin
                // Under stall a pending ECALL stays visible until decode consumes it.
                if (!bus.stall) begin
                    id_insn_nxt  = NOP;
                    id_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign bus.pc_out       = pc[IDX_W+1:2];
    assign bus.id_insn      = id_insn_q;
    assign bus.id_pc        = id_pc_q;
    assign bus.id_valid     = id_valid_q;
    assign bus.halted       = (state == HALT);
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, stall, redirect, misaligned trap, ECALL halt, PC wrap and async reset.
module tb_fetch_unit;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic clk;
    logic rst_n;
    logic rst_b_n;
    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    fetch_if #(.PC_W(32), .IDX_W(10)) bus_a ();
    fetch_if #(.PC_W(32), .IDX_W(10)) bus_b ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_W(32), .IDX_W(10)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    fetch_unit #(.RESET_PC(32'd4092), .PC_W(32), .IDX_W(10)) dut_b (
        .clk   (clk),
        .rst_n (rst_b_n),
        .bus   (bus_b.master)
    );

    // Combinational instruction memory shared by both instances.
    assign bus_a.insn_in = mem[bus_a.pc_out];
    assign bus_b.insn_in = mem[bus_b.pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013 + (i << 20);
        mem[0]    = 32'h0020_8093;
        mem[1]    = 32'h4031_0133;
        mem[2]    = 32'h0000_0293;
        mem[3]    = 32'h0010_0313;
        mem[5]    = ECALL;
        mem[16]   = 32'h00A0_0393;
        mem[1023] = 32'h0010_0513;

        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        bus_a.stall       = 1'b0;
        bus_a.redirect    = 1'b0;
        bus_a.redirect_pc = '0;
        bus_b.stall       = 1'b0;
        bus_b.redirect    = 1'b0;
        bus_b.redirect_pc = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_insn",   bus_a.id_insn, NOP);
        check("rst_id_pc",  bus_a.id_pc, 32'h0);
        check("rst_valid",  32'(bus_a.id_valid), 32'h0);
        check("rst_halted", 32'(bus_a.halted), 32'h0);
        check("rst_err",    32'(bus_a.misalign_err), 32'h0);
        check("rst_pc_out", 32'(bus_a.pc_out), 32'h0);

        // Boot and first fetches
        rst_n = 1'b1;
        tick();
        check("boot_valid",  32'(bus_a.id_valid), 32'h0);
        check("boot_pc_out", 32'(bus_a.pc_out), 32'h0);
        tick();
        check("f0_insn",  bus_a.id_insn, 32'h0020_8093);
        check("f0_id_pc", bus_a.id_pc, 32'h0);
        check("f0_valid", 32'(bus_a.id_valid), 32'h1);
        tick();
        check("f1_insn",   bus_a.id_insn, 32'h4031_0133);
        check("f1_id_pc",  bus_a.id_pc, 32'h4);
        check("f1_pc_out", 32'(bus_a.pc_out), 32'h2);
        tick();
        check("f2_id_pc",  bus_a.id_pc, 32'h8);
        check("f2_pc_out", 32'(bus_a.pc_out), 32'h3);

        // Stall holds everything for three cycles
        bus_a.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_id_pc",  bus_a.id_pc, 32'h8);
            check("stall_insn",   bus_a.id_insn, 32'h0000_0293);
            check("stall_valid",  32'(bus_a.id_valid), 32'h1);
            check("stall_pc_out", 32'(bus_a.pc_out), 32'h3);
        end
        bus_a.stall = 1'b0;
        tick();
        check("unstall_id_pc",  bus_a.id_pc, 32'hC);
        check("unstall_insn",   bus_a.id_insn, 32'h0010_0313);
        check("unstall_pc_out", 32'(bus_a.pc_out), 32'h4);

        // Redirect beats a simultaneous stall
        bus_a.stall       = 1'b1;
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 32'h40;
        tick();
        check("redir_valid",  32'(bus_a.id_valid), 32'h0);
        check("redir_insn",   bus_a.id_insn, NOP);
        check("redir_pc_out", 32'(bus_a.pc_out), 32'd16);
        bus_a.stall    = 1'b0;
        bus_a.redirect = 1'b0;
        tick();
        check("tgt_id_pc", bus_a.id_pc, 32'h40);
        check("tgt_valid", 32'(bus_a.id_valid), 32'h1);
        check("tgt_insn",  bus_a.id_insn, 32'h00A0_0393);

        // Misaligned target traps into HALT
        bus_a.redirect    = 1'b1;
        bus_a.redirect_pc = 32'h42;
        tick();
        check("mis_err",    32'(bus_a.misalign_err), 32'h1);
        check("mis_halted", 32'(bus_a.halted), 32'h1);
        check("mis_pc_out", 32'(bus_a.pc_out), 32'd17);
        check("mis_valid",  32'(bus_a.id_valid), 32'h0);
        bus_a.redirect_pc = 32'h0;
        tick();
        check("halt_redir_pc_out", 32'(bus_a.pc_out), 32'd17);
        check("halt_redir_halted", 32'(bus_a.halted), 32'h1);
        check("halt_err_sticky",   32'(bus_a.misalign_err), 32'h1);
        bus_a.redirect = 1'b0;

        // ECALL halt after a fresh reset
        rst_n = 1'b0;
        #1;
        check("rerst_err",    32'(bus_a.misalign_err), 32'h0);
        check("rerst_halted", 32'(bus_a.halted), 32'h0);
        check("rerst_pc_out", 32'(bus_a.pc_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("ecall_insn",   bus_a.id_insn, ECALL);
        check("ecall_id_pc",  bus_a.id_pc, 32'd20);
        check("ecall_valid",  32'(bus_a.id_valid), 32'h1);
        check("ecall_halted", 32'(bus_a.halted), 32'h1);
        check("ecall_pc_out", 32'(bus_a.pc_out), 32'd5);
        bus_a.stall = 1'b1;
        tick();
        check("ecall_hold_valid", 32'(bus_a.id_valid), 32'h1);
        check("ecall_hold_insn",  bus_a.id_insn, ECALL);
        bus_a.stall = 1'b0;
        tick();
        check("ecall_drain_valid", 32'(bus_a.id_valid), 32'h0);
        check("ecall_drain_insn",  bus_a.id_insn, NOP);
        for (int i = 0; i < 3; i++) tick();
        check("ecall_frozen_pc_out", 32'(bus_a.pc_out), 32'd5);
        check("ecall_frozen_halted", 32'(bus_a.halted), 32'h1);

        // Wrap from index 1023 to 0, then async reset mid-run
        check("wrap_rst_pc_out", 32'(bus_b.pc_out), 32'd1023);
        rst_b_n = 1'b1;
        tick();
        check("wrap_boot_valid", 32'(bus_b.id_valid), 32'h0);
        tick();
        check("wrap_f0_insn",   bus_b.id_insn, 32'h0010_0513);
        check("wrap_f0_id_pc",  bus_b.id_pc, 32'd4092);
        check("wrap_f0_pc_out", 32'(bus_b.pc_out), 32'h0);
        tick();
        check("wrap_f1_insn",   bus_b.id_insn, 32'h0020_8093);
        check("wrap_f1_id_pc",  bus_b.id_pc, 32'd4096);
        check("wrap_f1_valid",  32'(bus_b.id_valid), 32'h1);
        check("wrap_f1_pc_out", 32'(bus_b.pc_out), 32'h1);
        #2;
        rst_b_n = 1'b0;
        #1;
        check("async_rst_valid",  32'(bus_b.id_valid), 32'h0);
        check("async_rst_pc_out", 32'(bus_b.pc_out), 32'd1023);
        check("async_rst_insn",   bus_b.id_insn, NOP);
        check("async_rst_id_pc",  bus_b.id_pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
